// File: rtl/mem_request_arb_pkg.sv
// Shared types and width helpers for the memory request arbiter.
// Requests from several requesters are granted one at a time to a single memory port.
package mem_request_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Grant index width; a single channel still needs a 1-bit index.
  function automatic int gnt_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // The timeout counter only has to reach TIMEOUT-1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_request_arbiter_rr_pick.sv
// Combinational winner selection among pending channels.
// Supports round-robin (starts after ptr) or fixed priority (lowest index first).
module rr_pick
  import mem_request_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int RR  = 1
) (
  input  logic [NCH-1:0]            i_pend,
  input  logic [gnt_width(NCH)-1:0] i_ptr,
  output logic [gnt_width(NCH)-1:0] o_win,
  output logic                      o_valid
);

  localparam int GW = gnt_width(NCH);

  logic [GW-1:0] w_idx;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    o_win   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = (RR != 0) ? GW'((int'(i_ptr) + 1 + k) % NCH) : GW'(k);
      if (!o_valid && i_pend[w_idx]) begin
        o_valid = 1'b1;
        o_win   = w_idx;
      end
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Multi-channel memory request unit: arbitrates, holds memory enables until the
// access completes, and returns a one-cycle hit (plus err on timeout) with load data.
module mem_request_arbiter
  import mem_request_arb_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR      = 1,
  parameter int TIMEOUT = 0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NCH-1:0]                rreq,
  input  logic [NCH-1:0]                wreq,
  input  logic [NCH-1:0][AW-1:0]        addr,
  input  logic [NCH-1:0][DW-1:0]        wdata,
  output logic [NCH-1:0]                hit,
  output logic [NCH-1:0]                err,
  output logic [DW-1:0]                 rdata,
  output logic                          mREN,
  output logic                          mWEN,
  output logic [AW-1:0]                 mADDR,
  output logic [DW-1:0]                 mSTORE,
  input  logic                          mWAIT,
  input  logic [DW-1:0]                 mLOAD,
  output logic                          busy,
  output logic [gnt_width(NCH)-1:0]     gnt
);

  localparam int GW = gnt_width(NCH);
  localparam int CW = cnt_width(TIMEOUT);

  state_e         r_state;
  logic [GW-1:0]  r_ptr;
  logic [CW-1:0]  r_cnt;
  logic [NCH-1:0] w_pend;
  logic [GW-1:0]  w_win;
  logic           w_valid;
  logic           w_timeout;

  assign w_pend    = rreq | wreq;
  assign w_timeout = (TIMEOUT > 0) && (r_cnt == CW'(TIMEOUT - 1));

  rr_pick #(
    .NCH (NCH),
    .RR  (RR)
  ) u_pick (
    .i_pend  (w_pend),
    .i_ptr   (r_ptr),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  // NOTE: all state uses non-blocking assignments so each register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      hit     <= '0;
      err     <= '0;
      rdata   <= '0;
      mREN    <= 1'b0;
      mWEN    <= 1'b0;
      mADDR   <= '0;
      mSTORE  <= '0;
      busy    <= 1'b0;
      gnt     <= '0;
      r_cnt   <= '0;
      r_ptr   <= GW'(NCH - 1);
    end else begin
      hit <= '0;
      err <= '0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            gnt     <= w_win;
            mADDR   <= addr[w_win];
            mSTORE  <= wdata[w_win];
            mWEN    <= wreq[w_win];
            mREN    <= rreq[w_win] & ~wreq[w_win];
            r_cnt   <= '0;
            r_ptr   <= w_win;
            busy    <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (!mWAIT) begin
            if (mREN) rdata <= mLOAD;
            hit[gnt] <= 1'b1;
            mREN     <= 1'b0;
            mWEN     <= 1'b0;
            r_state  <= DONE;
          end else if (w_timeout) begin
            hit[gnt] <= 1'b1;
            err[gnt] <= 1'b1;
            mREN     <= 1'b0;
            mWEN     <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
